ysyx_24070016_exu_alu_sched: RTL

Two-requester scheduler that time-shares the single EXU ALU. Requester 0 is the main EXU issue path; requester 1 is the branch-compare/address-gen path. The block arbitrates round-robin with valid/ready handshakes and drives sel_aluop/alu_src1/alu_src2 from the granted requester. It registers alu_result/zero/less with an id and tag into a one-entry output stage under resp valid/ready backpressure.

---
 rtl/ysyx_24070016_exu_alu_sched_pkg.sv | 26 ++
 rtl/ysyx_24070016_rr_arb2.sv | 36 +++
 rtl/ysyx_24070016_exu_alu_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ysyx_24070016_exu_alu_sched_pkg.sv
// Shared constants for the EXU ALU scheduler: ALU op codes, requester ids, operand width.
package ysyx_24070016_exu_alu_sched_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALUOP_ADD  = 4'b0000;
    localparam logic [3:0] ALUOP_SLL  = 4'b0001;
    localparam logic [3:0] ALUOP_SLT  = 4'b0010;
    localparam logic [3:0] ALUOP_LUI  = 4'b0011;
    localparam logic [3:0] ALUOP_XOR  = 4'b0100;
    localparam logic [3:0] ALUOP_SRL  = 4'b0101;
    localparam logic [3:0] ALUOP_OR   = 4'b0110;
    localparam logic [3:0] ALUOP_AND  = 4'b0111;
    localparam logic [3:0] ALUOP_SUB  = 4'b1000;
    localparam logic [3:0] ALUOP_SLTU = 4'b1010;
    localparam logic [3:0] ALUOP_SRA  = 4'b1101;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_BRU = 1'b1;

    typedef enum logic {
        PREF_EXU = 1'b0,
        PREF_BRU = 1'b1
    } rr_pref_t;

endpackage

// File: rtl/ysyx_24070016_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester after each handshake.
module ysyx_24070016_rr_arb2
    import ysyx_24070016_exu_alu_sched_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    rr_pref_t rr_ptr;
    rr_pref_t rr_ptr_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= PREF_EXU;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        grant       = '0;
        rr_ptr_next = rr_ptr;
        if (valid == 2'b11) begin
            grant = (rr_ptr == PREF_EXU) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
        if (advance && (grant != 2'b00)) begin
            rr_ptr_next = grant[0] ? PREF_BRU : PREF_EXU;
        end
    end

endmodule

// File: rtl/ysyx_24070016_exu_alu_sched.sv
// Time-shares the EXU ALU between the issue path and the branch path with a one-entry result stage.
// Optional handshake/stall counters: define YSYX_24070016_ALU_SCHED_PERF_EN.
module ysyx_24070016_exu_alu_sched
    import ysyx_24070016_exu_alu_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned XLEN  = ysyx_24070016_exu_alu_sched_pkg::XLEN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req0_op,
    input  logic [XLEN-1:0]  req0_src1,
    input  logic [XLEN-1:0]  req0_src2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic [3:0]       req1_op,
    input  logic [XLEN-1:0]  req1_src1,
    input  logic [XLEN-1:0]  req1_src2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [3:0]       sel_aluop,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic             alu_less,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [XLEN-1:0]  resp_result,
    output logic             resp_zero,
`ifdef YSYX_24070016_ALU_SCHED_PERF_EN
    output logic             resp_less,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_stall
`else
    output logic             resp_less
`endif
);

    logic [1:0]       grant;
    logic             accept_ok;
    logic             fire;
    logic [TAG_W-1:0] grant_tag;

    assign accept_ok = ~resp_valid | resp_ready;
    assign fire      = |(req_valid & req_ready);

    ysyx_24070016_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   (req_valid),
        .advance (fire),
        .grant   (grant)
    );

    // Ready depends only on valid, the pointer and the output stage, never on the payload.
    always_comb begin
        req_ready = '0;
        if (!reset) begin
            req_ready = grant & {2{accept_ok}};
        end
    end

    always_comb begin
        sel_aluop = ALUOP_ADD;
        alu_src1  = '0;
        alu_src2  = '0;
        grant_tag = '0;
        if (grant[0]) begin
            sel_aluop = req0_op;
            alu_src1  = req0_src1;
            alu_src2  = req0_src2;
            grant_tag = req0_tag;
        end else if (grant[1]) begin
            sel_aluop = req1_op;
            alu_src1  = req1_src1;
            alu_src2  = req1_src2;
            grant_tag = req1_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_id     <= REQ_EXU;
            resp_tag    <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_less   <= 1'b0;
        end else if (fire) begin
            resp_valid  <= 1'b1;
            resp_id     <= req_ready[1] ? REQ_BRU : REQ_EXU;
            resp_tag    <= grant_tag;
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            resp_less   <= alu_less;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

`ifdef YSYX_24070016_ALU_SCHED_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (req_valid[0] & req_ready[0]) begin
                perf_grant0 <= perf_grant0 + 32'd1;
            end
            if (req_valid[1] & req_ready[1]) begin
                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if ((req_valid != 2'b00) && !fire) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
